// File: rtl/pc_sequencer.sv
// Next-PC controller for IF: PC register, redirect, stall and halt sequencing.
// Optional self-loop-as-halt behaviour is enabled by defining PC_SEQ_BRANCH_HOLD_EN.
module pc_sequencer #(
    parameter int              PC_W      = 5,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              STALL_MAX = 15,
    parameter int              CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  pc_plus1,
    output logic             cntrl_pc_src,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             stall_err,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int SC_W = $clog2(STALL_MAX + 2);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        HALT
    } state_t;

    state_t          state;
    logic [SC_W-1:0] stall_cnt;
    logic            taken;
    logic            self_loop;
    logic            at_limit;
    logic [PC_W-1:0] next_pc;

    assign pc_plus1     = pc_out + 1'b1;
    assign taken        = branch_en & branch_cond & (state != HALT);
    assign cntrl_pc_src = taken;
    assign next_pc      = taken ? branch_target : pc_plus1;
    // One more stall cycle would push the count past the legal maximum
    assign at_limit     = (stall_cnt >= SC_W'(STALL_MAX));

`ifdef PC_SEQ_BRANCH_HOLD_EN
    assign self_loop = taken & (branch_target == pc_out);
`else
    assign self_loop = 1'b0;
`endif

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        priority case (1'b1)
            state == HALT: begin
                flush_if_id = 1'b1;
            end
            taken: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            halt_req: begin
                if_id_write = 1'b1;
                flush_if_id = 1'b1;
            end
            stall_req: begin
                flush_id_ex = 1'b1;
            end
            default: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out    <= RESET_PC;
            state     <= RUN;
            stall_cnt <= '0;
            halted    <= 1'b0;
            stall_err <= 1'b0;
            taken_cnt <= '0;
        end else begin
            if (pc_write) begin
                pc_out <= next_pc;
            end
            if (taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
            priority case (1'b1)
                state == HALT: begin
                    // An expired stall can only be cleared by reset
                    if (resume && !stall_err) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                taken: begin
                    stall_cnt <= '0;
                    state     <= self_loop ? HALT : RUN;
                    halted    <= self_loop;
                end
                halt_req: begin
                    stall_cnt <= '0;
                    state     <= HALT;
                    halted    <= 1'b1;
                end
                stall_req: begin
                    if (at_limit) begin
                        stall_err <= 1'b1;
                        stall_cnt <= '0;
                        state     <= HALT;
                        halted    <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                        state     <= STALL;
                    end
                end
                default: begin
                    stall_cnt <= '0;
                    state     <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: abstract mode model checked every
// cycle, plus directed sequences with hand-computed PC expectations.
module tb_pc_sequencer;

    localparam int PC_W      = 5;
    localparam int CNT_W     = 8;
    localparam int STALL_MAX = 15;
    localparam int M_RUN     = 0;
    localparam int M_STALL   = 1;
    localparam int M_HALT    = 2;

    logic             clk           = 1'b0;
    logic             reset         = 1'b0;
    logic             stall_req     = 1'b0;
    logic             branch_en     = 1'b0;
    logic             branch_cond   = 1'b0;
    logic [PC_W-1:0]  branch_target = '0;
    logic             halt_req      = 1'b0;
    logic             resume        = 1'b0;
    logic [PC_W-1:0]  pc_out;
    logic [PC_W-1:0]  pc_plus1;
    logic             cntrl_pc_src;
    logic             pc_write;
    logic             if_id_write;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic             stall_err;
    logic [CNT_W-1:0] taken_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W(PC_W),
        .RESET_PC('0),
        .STALL_MAX(STALL_MAX),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall_req(stall_req),
        .branch_en(branch_en),
        .branch_cond(branch_cond),
        .branch_target(branch_target),
        .halt_req(halt_req),
        .resume(resume),
        .pc_out(pc_out),
        .pc_plus1(pc_plus1),
        .cntrl_pc_src(cntrl_pc_src),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .halted(halted),
        .stall_err(stall_err),
        .taken_cnt(taken_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: mode, PC, current stall length, sticky error, branch count
    int m_pc   = 0;
    int m_mode = M_RUN;
    int m_slen = 0;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    int e_plus1, n_pc, n_mode, n_slen, n_cnt;
    bit e_src, e_pw, e_ifw, e_fif, e_fex, n_err, tk;

    always_comb begin
        e_plus1 = (m_pc + 1) % (1 << PC_W);
        tk      = branch_en && branch_cond && (m_mode != M_HALT);
        e_src   = tk;
        e_pw    = 1'b0;
        e_ifw   = 1'b0;
        e_fif   = 1'b0;
        e_fex   = 1'b0;
        n_mode  = m_mode;
        n_slen  = m_slen;
        n_err   = m_err;
        n_cnt   = m_cnt;
        if (m_mode == M_HALT) begin
            e_fif = 1'b1;
            if (resume && !m_err) n_mode = M_RUN;
        end else if (tk) begin
            {e_pw, e_ifw, e_fif, e_fex} = 4'b1111;
            n_mode = M_RUN;
            n_slen = 0;
            n_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
`ifdef PC_SEQ_BRANCH_HOLD_EN
            if (int'(branch_target) == m_pc) n_mode = M_HALT;
`endif
        end else if (halt_req) begin
            e_ifw  = 1'b1;
            e_fif  = 1'b1;
            n_mode = M_HALT;
            n_slen = 0;
        end else if (stall_req) begin
            e_fex = 1'b1;
            if (m_slen + 1 > STALL_MAX) begin
                n_err  = 1'b1;
                n_mode = M_HALT;
                n_slen = 0;
            end else begin
                n_mode = M_STALL;
                n_slen = m_slen + 1;
            end
        end else begin
            e_pw   = 1'b1;
            e_ifw  = 1'b1;
            n_mode = M_RUN;
            n_slen = 0;
        end
        n_pc = e_pw ? (tk ? int'(branch_target) : e_plus1) : m_pc;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc   <= 0;
            m_mode <= M_RUN;
            m_slen <= 0;
            m_err  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_pc   <= n_pc;
            m_mode <= n_mode;
            m_slen <= n_slen;
            m_err  <= n_err;
            m_cnt  <= n_cnt;
        end
    end

    always @(negedge clk) begin
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus1", pc_plus1, e_plus1);
        chk("pc_src", cntrl_pc_src, e_src);
        chk("pc_write", pc_write, e_pw);
        chk("if_id_write", if_id_write, e_ifw);
        chk("flush_if_id", flush_if_id, e_fif);
        chk("flush_id_ex", flush_id_ex, e_fex);
        chk("halted", halted, m_mode == M_HALT);
        chk("stall_err", stall_err, m_err);
        chk("taken_cnt", taken_cnt, m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit st, bit be, bit bc, logic [PC_W-1:0] bt,
                          bit hr, bit rs);
        stall_req     = st;
        branch_en     = be;
        branch_cond   = bc;
        branch_target = bt;
        halt_req      = hr;
        resume        = rs;
    endtask

    task automatic idle(int n);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pc", pc_out, 0);
        chk("rst_cnt", taken_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", stall_err, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_if_id_write", if_id_write, 1);
        chk("rst_flushes", {flush_if_id, flush_id_ex}, 0);

        idle(4);
        chk("run_pc4", pc_out, 4);
        set_in(0, 1, 1, 5'b01010, 0, 0);
        #1;
        chk("br_src", cntrl_pc_src, 1);
        chk("br_flushes", {flush_if_id, flush_id_ex}, 2'b11);
        tick();
        chk("br_pc10", pc_out, 10);
        chk("br_cnt1", taken_cnt, 1);

        set_in(0, 1, 1, 7, 0, 0);
        tick();
        chk("br_pc7", pc_out, 7);
        set_in(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_pc", pc_out, 0);
        chk("async_rst_cnt", taken_cnt, 0);
        chk("async_rst_halted", halted, 0);
        #1 reset = 1'b0;
        idle(3);
        chk("post_rst_pc3", pc_out, 3);
        chk("post_rst_plus1", pc_plus1, 4);

        idle(1);
        set_in(0, 1, 0, 5'b01010, 0, 0);
        #1;
        chk("nt_src", cntrl_pc_src, 0);
        chk("nt_flushes", {flush_if_id, flush_id_ex}, 0);
        tick();
        chk("nt_pc5", pc_out, 5);

        idle(1);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            #1;
            chk("stall_ifw", if_id_write, 0);
            chk("stall_fex", flush_id_ex, 1);
            chk("stall_pc6", pc_out, 6);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("unstall_pw", pc_write, 1);
        tick();
        chk("unstall_pc7", pc_out, 7);

        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 20, 0, 0);
        #1;
        chk("stall_br_pw", pc_write, 1);
        tick();
        chk("stall_br_pc20", pc_out, 20);
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        chk("stall_br_pc21", pc_out, 21);

        set_in(0, 1, 1, 30, 0, 0);
        tick();
        chk("wrap_pc30", pc_out, 30);
        idle(2);
        chk("wrap_pc0", pc_out, 0);
        idle(1);
        chk("wrap_pc1", pc_out, 1);

        set_in(1, 0, 0, 0, 0, 0);
        repeat (15) tick();
        chk("stall15_err", stall_err, 0);
        tick();
        chk("stall16_err", stall_err, 1);
        chk("stall16_halted", halted, 1);
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        chk("err_resume_halted", halted, 1);
        chk("err_resume_pc", pc_out, 1);
        set_in(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("err_rst_clear", stall_err, 0);
        tick();
        reset = 1'b0;

        idle(9);
        chk("halt_pc9", pc_out, 9);
        set_in(0, 0, 0, 0, 1, 0);
        #1;
        chk("halt_req_fif", flush_if_id, 1);
        chk("halt_req_pw", pc_write, 0);
        tick();
        chk("halt_halted", halted, 1);
        set_in(1, 1, 1, 3, 1, 0);
        repeat (5) begin
            #1;
            chk("halt_src", cntrl_pc_src, 0);
            tick();
            chk("halt_hold_pc9", pc_out, 9);
        end
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        chk("resume_halted", halted, 0);
        chk("resume_pc9", pc_out, 9);
        idle(1);
        chk("resume_pc10", pc_out, 10);

        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 1, 0);
        #1;
        chk("stall_halt_ifw", if_id_write, 1);
        tick();
        chk("stall_halt_halted", halted, 1);
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        idle(1);
        chk("stall_halt_pc11", pc_out, 11);

        set_in(0, 1, 1, 25, 1, 0);
        tick();
        chk("br_halt_pc25", pc_out, 25);
        chk("br_halt_halted", halted, 0);

        set_in(0, 1, 1, 12, 0, 0);
        tick();
        tick();
        chk("self_loop_pc12", pc_out, 12);
        chk("self_loop_cnt", taken_cnt, 3);
`ifdef PC_SEQ_BRANCH_HOLD_EN
        chk("self_loop_halted", halted, 1);
`else
        chk("self_loop_halted", halted, 0);
`endif
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        idle(1);

        repeat (260) begin
            set_in(0, 1, 1, pc_out + 5'd3, 0, 0);
            tick();
        end
        chk("cnt_saturate", taken_cnt, 255);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the IF stage. It owns the PC register and produces pc_plus1, which feeds the sequential input of the PC-source mux. It also drives cntrl_pc_src, the mux select between pc_plus1 and the EX-stage branch target.
It sequences fetch across load-use stalls, taken-branch redirects and halt, and drives the pipeline-register write enables and flushes.

Parameters:
PC_W, 5, PC and address width
RESET_PC, 0, PC value loaded on reset
STALL_MAX, 15, longest legal consecutive stall in cycles; exceeding it is an error
CNT_W, 8, width of the taken-branch counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
stall_req  input  1  hazard unit load-use stall request
branch_en  input  1  a branch instruction is in EX this cycle
branch_cond  input  1  branch condition (zero flag) from EX
branch_target  input  PC_W  branch target address from the branch adder
halt_req  input  1  halt instruction decoded; stop fetch
resume  input  1  leave HALT; only honoured in HALT
pc_out  output  PC_W  current PC (registered)
pc_plus1  output  PC_W  pc_out+1 modulo 2^PC_W; sequential input to the PC mux
cntrl_pc_src  output  1  mux select: 1 = branch_target, 0 = pc_plus1
pc_write  output  1  PC register enable
if_id_write  output  1  IF/ID pipeline register enable
flush_if_id  output  1  synchronous clear of IF/ID at the next edge
flush_id_ex  output  1  synchronous clear of ID/EX at the next edge
halted  output  1  1 while in HALT
stall_err  output  1  sticky stall-timeout error
taken_cnt  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async, any state, mid-operation included):
  - pc_out=RESET_PC, state=RUN, stall counter=0, stall_err=0, taken_cnt=0.
  - Resulting combinational outputs: pc_write=1, if_id_write=1, flushes=0, halted=0.
- States are RUN, STALL and HALT.
- taken = branch_en & branch_cond & (state != HALT).
- cntrl_pc_src = taken (combinational, same cycle).
- Next PC = cntrl_pc_src ? branch_target : pc_plus1. It is loaded at the edge when pc_write=1.
- pc_plus1 wraps: 31 -> 0 for PC_W=5. No carry-out.
- Priority, highest first: reset > taken branch > halt_req > stall_req.
- Taken branch, in RUN or STALL:
  - pc_write=1, if_id_write=1, flush_if_id=1, flush_id_ex=1 in that cycle.
  - Next state is RUN. The stall is abandoned because the stalled instruction is on the wrong path.
  - Stall counter clears. taken_cnt increments, saturating at 2^CNT_W-1.
- RUN:
  - halt_req (no taken branch): pc_write=0, if_id_write=1, flush_if_id=1. Next state is HALT.
  - stall_req (no taken, no halt): pc_write=0, if_id_write=0, flush_id_ex=1 (bubble). Next state is STALL, stall counter=1.
  - Otherwise: pc_write=1, if_id_write=1, flushes=0.
- STALL:
  - While stall_req=1: pc_write=0, if_id_write=0, flush_id_ex=1, stall counter increments.
  - When the counter would exceed STALL_MAX: set stall_err (sticky until reset), go to HALT.
  - stall_req=0: pc_write=1, if_id_write=1, flushes=0, next state RUN, counter=0.
  - halt_req in STALL: same as in RUN.
- HALT:
  - pc_write=0, if_id_write=0, flush_if_id=1, flush_id_ex=0, halted=1, cntrl_pc_src=0.
  - branch_en, stall_req and halt_req are ignored.
  - resume=1: next state RUN; fetch restarts at the held pc_out.
  - resume=1 while stall_err=1 is ignored; only reset clears it.
- Simultaneous taken branch and halt_req: the branch wins and halt_req is dropped. The halt instruction is on the flushed wrong path.
- Latency:
  - Redirect: target appears on pc_out one edge after taken is sampled.
  - Branch penalty: 2 flushed instructions.

Optional Feature:
PC_SEQ_BRANCH_HOLD_EN.
- Defined: a taken branch whose branch_target equals pc_out (self-loop) is treated as halt_req. Required response: taken_cnt increments, PC loads the target, flushes assert, next state HALT.
- Undefined: a self-loop is an ordinary taken branch.

Test Plan:
1. Reset pulse mid-stream at PC=7, asynchronous, between edges -> pc_out=0 immediately; taken_cnt=0, state RUN; after release PC counts 0,1,2,3 on successive edges with pc_plus1=pc_out+1.
2. Free-run from PC=30 -> pc_out 30,31,0,1; cntrl_pc_src=0 throughout.
3. At PC=4: branch_en=1, branch_cond=1, branch_target=5'b01010 -> same cycle cntrl_pc_src=1, both flushes=1; next edge pc_out=10, taken_cnt=1. With branch_cond=0 instead -> pc_out=5, no flush.
4. stall_req high 3 cycles at PC=6 -> pc_out holds 6, if_id_write=0, flush_id_ex=1 each cycle; then PC=7. Variant: taken branch in the 2nd stall cycle -> redirect wins, state RUN.
5. stall_req held 16 cycles -> stall_err=1, halted=1; resume ignored; reset clears.
6. halt_req at PC=9 -> halted=1, pc_out stays 9 for 5 cycles despite branch_en/branch_cond=1; resume -> pc_out 9,10. With PC_SEQ_BRANCH_HOLD_EN: taken branch, target=12 at PC=12 -> halted=1, taken_cnt increments.
